ksa_byte_serial_ctrl: RTL and testbench
=======================================

Name: ksa_byte_serial_ctrl

Overview:
Controller that time-shares one 8-bit Kogge-Stone adder slice between two requesters. Each request is a wide add of 8*NBYTES bits, performed byte-serially, least significant byte first, with carry chained through a register. Round-robin arbitration selects the requester. Valid/ready handshakes are used on both request and response sides. The adder slice sits outside this block: it is purely combinational and carries a carry-in input.

Parameters:
NBYTES, 4, number of bytes per operand; operand width W = 8*NBYTES; legal range 1..16.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle when valid&ready
req0_a  in  W  requester 0 operand A
req0_b  in  W  requester 0 operand B
req1_valid  in  1  requester 1 has an operation
req1_ready  out  1  requester 1 accept
req1_a  in  W  requester 1 operand A
req1_b  in  W  requester 1 operand B
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  1  requester that owns the result
rsp_sum  out  W  A+B modulo 2^W
rsp_cout  out  1  carry out of bit W-1
add_a  out  8  byte of A driven to the adder slice
add_b  out  8  byte of B driven to the adder slice
add_cin  out  1  carry-in to the adder slice
add_sum  in  8  adder slice sum, valid in the same cycle
add_cout  in  1  adder slice carry-out, valid in the same cycle

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; byte counter = 0; carry register = 0.
  - Operand and result registers = 0; last_grant = 1, so req0 has priority first.
  - All outputs 0: rsp_valid, rsp_id, rsp_sum, rsp_cout, req*_ready, add_a, add_b, add_cin.
- FSM states: IDLE, CALC, DONE.
- IDLE, arbitration:
  - Only req0 valid -> grant 0. Only req1 valid -> grant 1.
  - Both valid -> grant the requester not equal to last_grant.
  - reqN_ready = 1 only for the granted requester, and only in IDLE. Ready may depend combinationally on valid.
  - On accept: capture A and B into shift registers, capture id, update last_grant, set counter=0 and carry=0, go to CALC.
  - No request -> stay in IDLE; last_grant unchanged.
- CALC, one byte per cycle:
  - add_a/add_b = low byte of the shift registers; add_cin = carry register (0 for byte 0).
  - On each edge: add_sum is shifted into the top of the result register from the MSB side; carry <= add_cout; operands shift right by 8; counter++.
  - After byte NBYTES-1: go to DONE, rsp_sum = full result, rsp_cout = add_cout of the last byte.
  - NBYTES=1 means CALC lasts exactly one cycle.
- DONE:
  - rsp_valid = 1; rsp_sum, rsp_cout and rsp_id stay stable until rsp_valid&rsp_ready.
  - Then go to IDLE, and rsp_valid drops the next cycle.
  - No request is accepted in CALC or DONE; both readys are 0.
- Outside CALC: add_a, add_b and add_cin are driven to 0.
- Latency: accept at edge T -> rsp_valid high from cycle T+NBYTES+1. With rsp_ready tied 1, the next accept is possible 2 cycles after rsp_valid rises. Throughput is one op per NBYTES+2 cycles.
- Reset mid-operation aborts the operation: no response is produced, and the pending request must be re-presented.
- Requester inputs are ignored while ready=0. A requester may drop valid without penalty.

Test Plan:
1. NBYTES=4; req0 A=0x000000FF, B=0x00000001 -> rsp_sum=0x00000100, rsp_cout=0, rsp_id=0, rsp_valid 5 cycles after accept edge; add_cin=1 on byte 1 only.
2. req1 A=0xFFFFFFFF, B=0x00000001 -> rsp_sum=0x00000000, rsp_cout=1, add_cin=1 on bytes 1..3.
3. req0 and req1 both held valid from reset -> grant order 0,1,0,1. rsp_id alternates. Sums match A+B for each, e.g. 0x12345678+0x11111111=0x23456789.
4. rsp_ready held 0 for 3 cycles in DONE -> rsp_valid, rsp_sum and rsp_id stable; both readys 0; after rsp_ready=1, IDLE next cycle and the accept follows.
5. rst_n pulsed low during CALC byte 2 -> all outputs 0 immediately. No rsp_valid. Next request completes correctly, and req0 is granted first if both valid.
6. NBYTES=1; A=0x80, B=0x80 -> rsp_sum=0x00, rsp_cout=1, rsp_valid 2 cycles after accept.

Source files
------------

// File: rtl/ksa_byte_serial_ctrl.sv
// ----------------------------------------------------------------------------
// ksa_byte_serial_ctrl
//
// Time-shares one external 8-bit adder slice between two requesters. Each
// accepted request is a W = 8*NBYTES bit add, performed one byte per cycle,
// least significant byte first, with the carry chained through a register.
// Requesters are arbitrated round-robin. Handshakes are valid/ready on both
// the request and response sides.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req0_* / req1_*         request channels: valid, ready, operands a and b
//   rsp_valid / rsp_ready   response handshake
//   rsp_id                  requester that owns the response
//   rsp_sum / rsp_cout      A+B modulo 2^W and the carry out of bit W-1
//   add_a/add_b/add_cin     byte operands and carry-in driven to the slice
//   add_sum/add_cout        combinational slice result, same cycle
// ----------------------------------------------------------------------------
module ksa_byte_serial_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [8*NBYTES-1:0]   req0_a,
    input  logic [8*NBYTES-1:0]   req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [8*NBYTES-1:0]   req1_a,
    input  logic [8*NBYTES-1:0]   req1_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [8*NBYTES-1:0]   rsp_sum,
    output logic                  rsp_cout,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic [CW-1:0]   r_cnt;
    logic            r_carry;
    logic            r_cout;
    logic            r_id;
    logic            r_last_grant;

    logic            w_grant0;
    logic            w_grant1;
    logic            w_accept;
    logic            w_last_byte;
    logic [W-1:0]    w_sum_shift;

    // Round-robin: a lone requester always wins; on contention the one that
    // was not granted last time wins. last_grant resets to 1 so req0 leads.
    assign w_grant0    = req0_valid & (~req1_valid | r_last_grant);
    assign w_grant1    = req1_valid & (~req0_valid | ~r_last_grant);
    assign w_accept    = (r_state == S_IDLE) & (w_grant0 | w_grant1);
    assign w_last_byte = (r_cnt == C_LAST);

    // Each new sum byte enters at the MSB end; after NBYTES shifts the first
    // byte has walked down to bits [7:0].
    generate
        if (NBYTES == 1) begin : g_shift_single
            assign w_sum_shift = add_sum;
        end else begin : g_shift_multi
            assign w_sum_shift = {add_sum, r_sum[W-1:8]};
        end
    endgenerate

    assign rsp_sum  = r_sum;
    assign rsp_cout = r_cout;
    assign rsp_id   = r_id;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake / slice outputs
    always_comb begin
        w_state_next = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp_valid    = 1'b0;
        add_a        = 8'd0;
        add_b        = 8'd0;
        add_cin      = 1'b0;
        case (r_state)
            S_IDLE: begin
                req0_ready = w_grant0;
                req1_ready = w_grant1;
                if (w_grant0 | w_grant1) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                add_a   = r_a[7:0];
                add_b   = r_b[7:0];
                add_cin = r_carry;
                if (w_last_byte) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: operand shifters, result accumulator, carry chain, bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
            r_cnt        <= '0;
            r_carry      <= 1'b0;
            r_cout       <= 1'b0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_accept) begin
                r_a          <= w_grant1 ? req1_a : req0_a;
                r_b          <= w_grant1 ? req1_b : req0_b;
                r_id         <= w_grant1;
                r_last_grant <= w_grant1;
                r_cnt        <= '0;
                r_carry      <= 1'b0;
            end else if (r_state == S_CALC) begin
                r_sum   <= w_sum_shift;
                r_carry <= add_cout;
                r_a     <= r_a >> 8;
                r_b     <= r_b >> 8;
                r_cnt   <= r_cnt + 1'b1;
                if (w_last_byte) begin
                    r_cout <= add_cout;
                end
            end
        end
    end

endmodule

// File: tb/tb_ksa_byte_serial_ctrl.sv
module tb_ksa_byte_serial_ctrl;

    typedef struct {
        logic        id;
        logic [31:0] sum;
        logic        cout;
        logic [3:0]  mask;   // bit i = expected add_cin on byte i
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- NBYTES=4 instance ----------------
    logic        req0_valid = 0, req1_valid = 0, rsp_ready = 1;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0, rsp_sum;
    logic [7:0]  add_a, add_b, add_sum;
    logic        add_cin, add_cout;

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    ksa_byte_serial_ctrl #(.NBYTES(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    // ---------------- NBYTES=1 instance ----------------
    logic       s_req0_valid = 0, s_req1_valid = 0, s_rsp_ready = 1;
    logic       s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_rsp_cout;
    logic [7:0] s_req0_a = 0, s_req0_b = 0, s_req1_a = 0, s_req1_b = 0, s_rsp_sum;
    logic [7:0] s_add_a, s_add_b, s_add_sum;
    logic       s_add_cin, s_add_cout;

    assign {s_add_cout, s_add_sum} = {1'b0, s_add_a} + {1'b0, s_add_b} + {8'd0, s_add_cin};

    ksa_byte_serial_ctrl #(.NBYTES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_a(s_req0_a), .req0_b(s_req0_b),
        .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_a(s_req1_a), .req1_b(s_req1_b),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id),
        .rsp_sum(s_rsp_sum), .rsp_cout(s_rsp_cout),
        .add_a(s_add_a), .add_b(s_add_b), .add_cin(s_add_cin),
        .add_sum(s_add_sum), .add_cout(s_add_cout)
    );

    exp_t q4[$];
    exp_t q1[$];
    logic [31:0] va0[4], vb0[4], va1[4], vb1[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic push(input bit d, input logic id, input logic [31:0] sum,
                        input logic cout, input logic [3:0] mask);
        exp_t e;
        e.id = id; e.sum = sum; e.cout = cout; e.mask = mask;
        if (d) q1.push_back(e);
        else   q4.push_back(e);
    endtask

    task automatic drive(input bit d, input bit which, input logic v,
                         input logic [31:0] a, input logic [31:0] b);
        if (!d) begin
            if (!which) begin req0_valid = v; req0_a = a; req0_b = b; end
            else        begin req1_valid = v; req1_a = a; req1_b = b; end
        end else begin
            if (!which) begin s_req0_valid = v; s_req0_a = a[7:0]; s_req0_b = b[7:0]; end
            else        begin s_req1_valid = v; s_req1_a = a[7:0]; s_req1_b = b[7:0]; end
        end
    endtask

    // Present n0 ops on req0 and n1 ops on req1 concurrently, advancing each
    // requester to its next vector once the handshake is observed.
    task automatic run_ops(input bit d, input int n0, input int n1);
        int k0 = 0;
        int k1 = 0;
        int t  = 0;
        bit acc0, acc1;
        @(posedge clk); #1;
        if (n0 > 0) drive(d, 1'b0, 1'b1, va0[0], vb0[0]);
        if (n1 > 0) drive(d, 1'b1, 1'b1, va1[0], vb1[0]);
        while ((k0 < n0 || k1 < n1) && t < 300) begin
            @(negedge clk);
            t++;
            acc0 = d ? (s_req0_valid && s_req0_ready) : (req0_valid && req0_ready);
            acc1 = d ? (s_req1_valid && s_req1_ready) : (req1_valid && req1_ready);
            @(posedge clk); #1;
            if (acc0) begin
                k0++;
                if (k0 < n0) drive(d, 1'b0, 1'b1, va0[k0], vb0[k0]);
                else         drive(d, 1'b0, 1'b0, 32'd0, 32'd0);
            end
            if (acc1) begin
                k1++;
                if (k1 < n1) drive(d, 1'b1, 1'b1, va1[k1], vb1[k1]);
                else         drive(d, 1'b1, 1'b0, 32'd0, 32'd0);
            end
        end
        chk("accepts", 64'(k0 + k1), 64'(n0 + n1));
    endtask

    task automatic drain();
        int t = 0;
        while ((q4.size() != 0 || q1.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 64'(q4.size() + q1.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- monitor, NBYTES=4 ----------------
    bit          m_busy = 0, m_prev = 0, m_abbad = 0;
    int          m_acc = 0;
    int          m_dly;
    logic [31:0] m_a, m_b, m_hsum;
    logic [3:0]  m_mask;
    logic        m_hid, m_hcout;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            m_busy = 0;
            m_prev = 0;
        end else begin
            m_dly = cyc - m_acc;
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                chk("single_grant", 64'(req0_ready & req1_ready), 64'd0);
                m_busy  = 1;
                m_acc   = cyc;
                m_a     = req0_ready ? req0_a : req1_a;
                m_b     = req0_ready ? req0_b : req1_b;
                m_mask  = 4'd0;
                m_abbad = 0;
            end else if (m_busy && m_dly >= 1 && m_dly <= 4) begin
                m_mask[m_dly-1] = add_cin;
                if (add_a !== m_a[8*(m_dly-1) +: 8] || add_b !== m_b[8*(m_dly-1) +: 8])
                    m_abbad = 1;
            end
            if (rsp_valid) begin
                chk("done_quiet", 64'({req0_ready, req1_ready, add_a, add_b, add_cin}), 64'd0);
                if (!m_prev) begin
                    if (q4.size() == 0) begin
                        chk("unexpected_rsp", 64'd1, 64'd0);
                    end else begin
                        e = q4.pop_front();
                        chk("rsp_id",   64'(rsp_id),   64'(e.id));
                        chk("rsp_sum",  64'(rsp_sum),  64'(e.sum));
                        chk("rsp_cout", 64'(rsp_cout), 64'(e.cout));
                        chk("cin_bytes", 64'(m_mask),  64'(e.mask));
                        chk("latency",  64'(m_dly),    64'd5);
                        chk("slice_operands", 64'(m_abbad), 64'd0);
                    end
                    m_busy = 0;
                    m_hsum = rsp_sum; m_hid = rsp_id; m_hcout = rsp_cout;
                end else begin
                    chk("rsp_stable", 64'({rsp_id, rsp_cout, rsp_sum}), 64'({m_hid, m_hcout, m_hsum}));
                end
            end
            m_prev = rsp_valid;
        end
    end

    // ---------------- monitor, NBYTES=1 ----------------
    bit         s_prev = 0;
    int         s_acc = 0;
    logic [7:0] s_a, s_b;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            s_prev = 0;
        end else begin
            if ((s_req0_valid && s_req0_ready) || (s_req1_valid && s_req1_ready)) begin
                s_acc = cyc;
                s_a   = s_req0_ready ? s_req0_a : s_req1_a;
                s_b   = s_req0_ready ? s_req0_b : s_req1_b;
            end else if (cyc - s_acc == 1 && !s_rsp_valid) begin
                chk("d1_slice", 64'({s_add_a, s_add_b, s_add_cin}), 64'({s_a, s_b, 1'b0}));
            end
            if (s_rsp_valid && !s_prev) begin
                if (q1.size() == 0) begin
                    chk("d1_unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    e = q1.pop_front();
                    chk("d1_rsp_id",   64'(s_rsp_id),   64'(e.id));
                    chk("d1_rsp_sum",  64'(s_rsp_sum),  64'(e.sum));
                    chk("d1_rsp_cout", 64'(s_rsp_cout), 64'(e.cout));
                    chk("d1_latency",  64'(cyc - s_acc), 64'd2);
                end
            end
            s_prev = s_rsp_valid;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int t;
        #3;
        chk("reset_outputs4", 64'({rsp_valid, rsp_id, rsp_sum, rsp_cout, req0_ready,
                                   req1_ready, add_a, add_b, add_cin}), 64'd0);
        chk("reset_outputs1", 64'({s_rsp_valid, s_rsp_id, s_rsp_sum, s_rsp_cout, s_req0_ready,
                                   s_req1_ready, s_add_a, s_add_b, s_add_cin}), 64'd0);
        #19 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Carry out of byte 0 only
        va0[0] = 32'h0000_00FF; vb0[0] = 32'h0000_0001;
        push(0, 1'b0, 32'h0000_0100, 1'b0, 4'b0010);
        run_ops(0, 1, 0);

        // Carry ripples through every byte and out of the top
        va1[0] = 32'hFFFF_FFFF; vb1[0] = 32'h0000_0001;
        push(0, 1'b1, 32'h0000_0000, 1'b1, 4'b1110);
        run_ops(0, 0, 1);

        // Contention: both held valid, grants alternate 0,1,0,1
        va0[0] = 32'h1234_5678; vb0[0] = 32'h1111_1111;
        va0[1] = 32'h0000_FFFF; vb0[1] = 32'h0000_0001;
        va1[0] = 32'h8000_0000; vb1[0] = 32'h8000_0000;
        va1[1] = 32'hFFFF_FFFF; vb1[1] = 32'hFFFF_FFFF;
        push(0, 1'b0, 32'h2345_6789, 1'b0, 4'b0000);
        push(0, 1'b1, 32'h0000_0000, 1'b1, 4'b0000);
        push(0, 1'b0, 32'h0001_0000, 1'b0, 4'b0110);
        push(0, 1'b1, 32'hFFFF_FFFE, 1'b1, 4'b1110);
        run_ops(0, 2, 2);
        drain();

        // Back-pressure: response held 3 cycles while req1 waits
        va0[0] = 32'h0101_0101; vb0[0] = 32'h0202_0202;
        va1[0] = 32'h00FF_00FF; vb1[0] = 32'h0001_0001;
        push(0, 1'b0, 32'h0303_0303, 1'b0, 4'b0000);
        push(0, 1'b1, 32'h0100_0100, 1'b0, 4'b1010);
        rsp_ready = 1'b0;
        fork
            run_ops(0, 1, 1);
            begin
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!rsp_valid && t < 100);
                chk("bp_valid_rise", 64'(rsp_valid), 64'd1);
                repeat (2) begin
                    @(negedge clk);
                    chk("bp_valid_held", 64'({rsp_valid, rsp_id}), 64'({1'b1, 1'b0}));
                end
                #1 rsp_ready = 1'b1;
                @(negedge clk);
                chk("bp_valid_drop", 64'(rsp_valid), 64'd0);
                chk("bp_next_accept", 64'(req1_ready), 64'd1);
            end
        join
        drain();

        // Reset during byte 2 aborts the op and restores req0 priority
        va0[0] = 32'hAAAA_AAAA; vb0[0] = 32'h5555_5555;
        push(0, 1'b0, 32'hFFFF_FFFF, 1'b0, 4'b0000);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, va0[0], vb0[0]);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req0_ready && t < 50);
        chk("abort_accept", 64'(req0_ready), 64'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        q4.delete(q4.size() - 1);
        #1;
        chk("midop_reset_outputs", 64'({rsp_valid, rsp_id, rsp_sum, rsp_cout, req0_ready,
                                        req1_ready, add_a, add_b, add_cin}), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_rsp_after_abort", 64'(rsp_valid), 64'd0);
        va0[0] = 32'h0000_0001; vb0[0] = 32'h0000_0002;
        va1[0] = 32'h7FFF_FFFF; vb1[0] = 32'h0000_0001;
        push(0, 1'b0, 32'h0000_0003, 1'b0, 4'b0000);
        push(0, 1'b1, 32'h8000_0000, 1'b0, 4'b1110);
        run_ops(0, 1, 1);
        drain();

        // Single-byte configuration
        va0[0] = 32'h80; vb0[0] = 32'h80;
        push(1, 1'b0, 32'h00, 1'b1, 4'b0000);
        run_ops(1, 1, 0);
        va1[0] = 32'h7F; vb1[0] = 32'h01;
        push(1, 1'b1, 32'h80, 1'b0, 4'b0000);
        run_ops(1, 0, 1);
        va0[0] = 32'hFF; vb0[0] = 32'hFF;
        va1[0] = 32'h01; vb1[0] = 32'h02;
        push(1, 1'b0, 32'hFE, 1'b1, 4'b0000);
        push(1, 1'b1, 32'h03, 1'b0, 4'b0000);
        run_ops(1, 1, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
